// File: rtl/prime_seq_monitor_if.sv
// Bundles the prime_seq pulse input and all monitor status outputs.
// master drives the pulse train; slave is the monitor.
interface prime_seq_monitor_if;
   logic        prime_seq;
   logic        seq_done;
   logic        seq_ok;
   logic [7:0]  seq_pulse_cnt;
   logic [7:0]  seq_expected;
   logic        len_err;
   logic [31:0] seq_total;
   logic [15:0] err_total;

   modport master (
      output prime_seq,
      input  seq_done, seq_ok, seq_pulse_cnt, seq_expected, len_err, seq_total, err_total
   );

   modport slave (
      input  prime_seq,
      output seq_done, seq_ok, seq_pulse_cnt, seq_expected, len_err, seq_total, err_total
   );
endinterface

// File: rtl/prime_seq_monitor.sv
// Measures prime_seq pulse widths, groups pulses into bursts and checks burst sizes against a prime table.
// Optional PRIME_SEQ_MON_SYNC_EN inserts a 2-flop input synchronizer (+2 cycles on all latencies).
module prime_seq_monitor #(
   parameter logic [31:0] PULSE_LEN_COUNT = 32'h007F_27C2,
   parameter logic [31:0] LEN_TOL         = 32'h0000_1000,
   parameter logic [31:0] SEQ_GAP_MIN     = 32'h017D_7746,
   parameter int unsigned NUM_PRIMES      = 11
) (
   input  logic                clk,
   input  logic                rst,
   prime_seq_monitor_if.slave  bus
);

   localparam logic [1:0] ST_ARM  = 2'd0;
   localparam logic [1:0] ST_GAP  = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;

   localparam logic [32:0] LEN_LO   = (LEN_TOL > PULSE_LEN_COUNT) ? 33'd0
                                      : ({1'b0, PULSE_LEN_COUNT} - {1'b0, LEN_TOL});
   localparam logic [32:0] LEN_HI   = {1'b0, PULSE_LEN_COUNT} + {1'b0, LEN_TOL};
   localparam logic [3:0]  IDX_LAST = 4'(NUM_PRIMES - 1);

   function automatic logic [7:0] prime_at(input logic [3:0] i);
      case (i)
         4'd0:    prime_at = 8'd2;
         4'd1:    prime_at = 8'd3;
         4'd2:    prime_at = 8'd5;
         4'd3:    prime_at = 8'd7;
         4'd4:    prime_at = 8'd11;
         4'd5:    prime_at = 8'd13;
         4'd6:    prime_at = 8'd17;
         4'd7:    prime_at = 8'd19;
         4'd8:    prime_at = 8'd23;
         4'd9:    prime_at = 8'd29;
         4'd10:   prime_at = 8'd31;
         default: prime_at = 8'd2;
      endcase
   endfunction

   logic prime_s;

`ifdef PRIME_SEQ_MON_SYNC_EN
   logic sync1_q, sync1_d, sync2_q, sync2_d;

   always_comb begin
      sync1_d = bus.prime_seq;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign prime_s = sync2_q;
`else
   assign prime_s = bus.prime_seq;
`endif

   logic [1:0]  state_q, state_d;
   logic [31:0] gap_cnt_q, gap_cnt_d;
   logic [31:0] width_cnt_q, width_cnt_d;
   logic [7:0]  pulse_cnt_q, pulse_cnt_d;
   logic        grp_len_bad_q, grp_len_bad_d;
   logic [3:0]  idx_q, idx_d;
   logic        seq_done_q, seq_done_d;
   logic        seq_ok_q, seq_ok_d;
   logic [7:0]  seq_pulse_cnt_q, seq_pulse_cnt_d;
   logic [7:0]  seq_expected_q, seq_expected_d;
   logic        len_err_q, len_err_d;
   logic [31:0] seq_total_q, seq_total_d;
   logic [15:0] err_total_q, err_total_d;

   logic       close;
   logic       match;
   logic       width_ok;
   logic [7:0] exp_prime;

   always_comb begin
      state_d         = state_q;
      gap_cnt_d       = gap_cnt_q;
      width_cnt_d     = width_cnt_q;
      pulse_cnt_d     = pulse_cnt_q;
      grp_len_bad_d   = grp_len_bad_q;
      idx_d           = idx_q;
      seq_done_d      = 1'b0;
      seq_ok_d        = seq_ok_q;
      seq_pulse_cnt_d = seq_pulse_cnt_q;
      seq_expected_d  = seq_expected_q;
      len_err_d       = 1'b0;
      seq_total_d     = seq_total_q;
      err_total_d     = err_total_q;

      exp_prime = prime_at(idx_q);
      match     = (pulse_cnt_q == exp_prime);
      width_ok  = ({1'b0, width_cnt_q} >= LEN_LO) && ({1'b0, width_cnt_q} <= LEN_HI);
      // A rise one cycle before the gap saturates leaves gap_cnt short, so it joins the group.
      close     = (state_q == ST_GAP) && (gap_cnt_q == SEQ_GAP_MIN) && (pulse_cnt_q != 8'd0);

      case (state_q)
         ST_ARM: begin
            if (!prime_s) begin
               state_d   = ST_GAP;
               gap_cnt_d = 32'd1;
            end
         end
         ST_GAP: begin
            if (close) begin
               seq_done_d      = 1'b1;
               seq_ok_d        = match && !grp_len_bad_q;
               seq_pulse_cnt_d = pulse_cnt_q;
               seq_expected_d  = exp_prime;
               seq_total_d     = seq_total_q + 32'd1;
               if (!(match && !grp_len_bad_q) && (err_total_q != '1))
                  err_total_d = err_total_q + 16'd1;
               pulse_cnt_d     = 8'd0;
               grp_len_bad_d   = 1'b0;
               if (!match && (pulse_cnt_q == 8'd2))
                  idx_d = 4'd1;
               else
                  idx_d = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
            end
            if (prime_s) begin
               state_d     = ST_HIGH;
               width_cnt_d = 32'd1;
               if (close)
                  pulse_cnt_d = 8'd1;
               else if (pulse_cnt_q != '1)
                  pulse_cnt_d = pulse_cnt_q + 8'd1;
            end else if (gap_cnt_q != SEQ_GAP_MIN) begin
               gap_cnt_d = gap_cnt_q + 32'd1;
            end
         end
         ST_HIGH: begin
            if (prime_s) begin
               if (width_cnt_q != '1)
                  width_cnt_d = width_cnt_q + 32'd1;
            end else begin
               state_d   = ST_GAP;
               gap_cnt_d = 32'd1;
               if (!width_ok) begin
                  len_err_d     = 1'b1;
                  grp_len_bad_d = 1'b1;
               end
            end
         end
         default: state_d = ST_ARM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_ARM;
         gap_cnt_q       <= '0;
         width_cnt_q     <= '0;
         pulse_cnt_q     <= '0;
         grp_len_bad_q   <= 1'b0;
         idx_q           <= '0;
         seq_done_q      <= 1'b0;
         seq_ok_q        <= 1'b0;
         seq_pulse_cnt_q <= '0;
         seq_expected_q  <= '0;
         len_err_q       <= 1'b0;
         seq_total_q     <= '0;
         err_total_q     <= '0;
      end else begin
         state_q         <= state_d;
         gap_cnt_q       <= gap_cnt_d;
         width_cnt_q     <= width_cnt_d;
         pulse_cnt_q     <= pulse_cnt_d;
         grp_len_bad_q   <= grp_len_bad_d;
         idx_q           <= idx_d;
         seq_done_q      <= seq_done_d;
         seq_ok_q        <= seq_ok_d;
         seq_pulse_cnt_q <= seq_pulse_cnt_d;
         seq_expected_q  <= seq_expected_d;
         len_err_q       <= len_err_d;
         seq_total_q     <= seq_total_d;
         err_total_q     <= err_total_d;
      end
   end

   assign bus.seq_done      = seq_done_q;
   assign bus.seq_ok        = seq_ok_q;
   assign bus.seq_pulse_cnt = seq_pulse_cnt_q;
   assign bus.seq_expected  = seq_expected_q;
   assign bus.len_err       = len_err_q;
   assign bus.seq_total     = seq_total_q;
   assign bus.err_total     = err_total_q;

endmodule

// File: tb/tb_prime_seq_monitor.sv
// Scoreboard bench for prime_seq_monitor with PULSE_LEN_COUNT=4, LEN_TOL=1, SEQ_GAP_MIN=12, NUM_PRIMES=4.
// Expected closes are pushed when a burst is driven and popped when seq_done is observed.
module tb_prime_seq_monitor;

   localparam int PL  = 4;
   localparam int TOL = 1;
   localparam int GAP = 12;
   localparam int NP  = 4;
`ifdef PRIME_SEQ_MON_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   typedef struct packed {
      logic [7:0]  cnt;
      logic [7:0]  expct;
      logic        ok;
      logic [31:0] total;
      logic [15:0] errt;
      logic [31:0] cyc;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   prime_seq_monitor_if bus ();

   prime_seq_monitor #(
      .PULSE_LEN_COUNT (32'd4),
      .LEN_TOL         (32'd1),
      .SEQ_GAP_MIN     (32'd12),
      .NUM_PRIMES      (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          compared   = 0;
   int          mismatched = 0;
   int unsigned cyc        = 0;
   int unsigned last_fall  = 0;
   rec_t        exp_q[$];
   rec_t        obs_q[$];
   int unsigned len_q[$];
   int unsigned len_exp_q[$];
   int          m_idx   = 0;
   int          m_total = 0;
   int          m_err   = 0;
   int          tbl[11] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      rec_t r;
      if (bus.seq_done === 1'b1) begin
         r.cnt   = bus.seq_pulse_cnt;
         r.expct = bus.seq_expected;
         r.ok    = bus.seq_ok;
         r.total = bus.seq_total;
         r.errt  = bus.err_total;
         r.cyc   = cyc;
         obs_q.push_back(r);
      end
      if (bus.len_err === 1'b1) len_q.push_back(cyc);
   end

   function automatic void model_push(input int cnt, input bit bad);
      rec_t e;
      bit   match;
      bit   ok;
      match = (cnt == tbl[m_idx]);
      ok    = match && !bad;
      m_total++;
      if (!ok && m_err < 65535) m_err++;
      e.cnt   = 8'(cnt);
      e.expct = 8'(tbl[m_idx]);
      e.ok    = ok;
      e.total = 32'(m_total);
      e.errt  = 16'(m_err);
      e.cyc   = last_fall + GAP + 1 + SYNC_LAT;
      m_idx   = (!match && cnt == 2) ? 1 : (m_idx + 1) % NP;
      exp_q.push_back(e);
   endfunction

   function automatic void clear_all();
      exp_q.delete();
      obs_q.delete();
      len_q.delete();
      len_exp_q.delete();
      m_idx   = 0;
      m_total = 0;
      m_err   = 0;
   endfunction

   task automatic drive(input logic v, input int n);
      repeat (n) begin
         @(negedge clk);
         bus.prime_seq = v;
      end
   endtask

   // One pulse of width w followed by `low` sampled low cycles.
   task automatic pulse(input int w, input int low, input bit bad);
      drive(1'b1, w);
      @(negedge clk);
      bus.prime_seq = 1'b0;
      last_fall = cyc;
      if (bad) len_exp_q.push_back(cyc + 1 + SYNC_LAT);
      drive(1'b0, low - 1);
   endtask

   task automatic burst(input int n, input int bad_i, input int bad_w, input int low);
      bit bad = 0;
      for (int i = 0; i < n; i++) begin
         int w;
         bit b;
         w = (i == bad_i) ? bad_w : PL;
         b = (w < PL - TOL) || (w > PL + TOL);
         bad |= b;
         pulse(w, low, b);
      end
      model_push(n, bad);
   endtask

   task automatic do_reset(input logic p);
      @(negedge clk);
      rst = 1'b1;
      bus.prime_seq = p;
      repeat (3) @(negedge clk);
      clear_all();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      bus.prime_seq = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if ({bus.seq_done, bus.seq_ok, bus.len_err, bus.seq_pulse_cnt, bus.seq_expected,
           bus.seq_total, bus.err_total} !== 67'd0) begin
         mismatched++;
         $display("FAIL reset_outputs: got done=%b ok=%b len=%b cnt=%0d exp=%0d tot=%0d err=%0d, want all 0",
                  bus.seq_done, bus.seq_ok, bus.len_err, bus.seq_pulse_cnt, bus.seq_expected,
                  bus.seq_total, bus.err_total);
      end
      clear_all();
      rst = 1'b0;
      drive(1'b0, 20);
      compared++;
      if (obs_q.size() != 0 || bus.seq_total !== 32'd0) begin
         mismatched++;
         $display("FAIL reset_idle: got closes=%0d tot=%0d, want 0 closes tot=0", obs_q.size(), bus.seq_total);
      end
   endtask

   task automatic test_prime_bursts;
      int sizes[5] = '{2, 3, 5, 7, 2};
      do_reset(1'b0);
      drive(1'b0, 5);
      foreach (sizes[i]) begin
         burst(sizes[i], -1, 0, 6);
         drive(1'b0, 14);
      end
      drive(1'b0, 6);
      while (exp_q.size() > 0) begin
         rec_t e, o;
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("FAIL t1_seq: got no seq_done, want cnt=%0d exp=%0d", e.cnt, e.expct);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("FAIL t1_seq: got cnt=%0d exp=%0d ok=%0b tot=%0d err=%0d at=%0d; want cnt=%0d exp=%0d ok=%0b tot=%0d err=%0d at=%0d",
                        o.cnt, o.expct, o.ok, o.total, o.errt, o.cyc, e.cnt, e.expct, e.ok, e.total, e.errt, e.cyc);
            end
         end
      end
      compared++;
      if (obs_q.size() != 0 || len_q.size() != 0) begin
         mismatched++;
         $display("FAIL t1_extra: got extra closes=%0d len_err=%0d, want 0 and 0", obs_q.size(), len_q.size());
      end
      compared++;
      if (bus.seq_total !== 32'(m_total) || bus.err_total !== 16'(m_err)) begin
         mismatched++;
         $display("FAIL t1_totals: got tot=%0d err=%0d, want tot=%0d err=%0d", bus.seq_total, bus.err_total, m_total, m_err);
      end
   endtask

   task automatic test_len_err;
      burst(3, 1, 7, 6);
      drive(1'b0, 20);
      while (exp_q.size() > 0) begin
         rec_t e, o;
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("FAIL t2_seq: got no seq_done, want cnt=%0d exp=%0d", e.cnt, e.expct);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("FAIL t2_seq: got cnt=%0d exp=%0d ok=%0b tot=%0d err=%0d at=%0d; want cnt=%0d exp=%0d ok=%0b tot=%0d err=%0d at=%0d",
                        o.cnt, o.expct, o.ok, o.total, o.errt, o.cyc, e.cnt, e.expct, e.ok, e.total, e.errt, e.cyc);
            end
         end
      end
      while (len_exp_q.size() > 0) begin
         int unsigned el;
         el = len_exp_q.pop_front();
         compared++;
         if (len_q.size() == 0) begin
            mismatched++;
            $display("FAIL t2_len_err: got no strobe, want strobe at %0d", el);
         end else if (len_q[0] !== el) begin
            mismatched++;
            $display("FAIL t2_len_err: got strobe at %0d, want at %0d", len_q[0], el);
            void'(len_q.pop_front());
         end else begin
            void'(len_q.pop_front());
         end
      end
      compared++;
      if (len_q.size() != 0 || obs_q.size() != 0) begin
         mismatched++;
         $display("FAIL t2_extra: got extra len_err=%0d closes=%0d, want 0 and 0", len_q.size(), obs_q.size());
      end
   endtask

   task automatic test_resync;
      int sizes[4] = '{2, 4, 2, 3};
      do_reset(1'b0);
      drive(1'b0, 5);
      foreach (sizes[i]) begin
         burst(sizes[i], -1, 0, 6);
         drive(1'b0, 14);
      end
      drive(1'b0, 6);
      while (exp_q.size() > 0) begin
         rec_t e, o;
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("FAIL t3_seq: got no seq_done, want cnt=%0d exp=%0d", e.cnt, e.expct);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("FAIL t3_seq: got cnt=%0d exp=%0d ok=%0b tot=%0d err=%0d at=%0d; want cnt=%0d exp=%0d ok=%0b tot=%0d err=%0d at=%0d",
                        o.cnt, o.expct, o.ok, o.total, o.errt, o.cyc, e.cnt, e.expct, e.ok, e.total, e.errt, e.cyc);
            end
         end
      end
   endtask

   task automatic test_armed_release;
      do_reset(1'b1);
      drive(1'b1, 3);
      drive(1'b0, 10);
      burst(2, -1, 0, 6);
      drive(1'b0, 20);
      while (exp_q.size() > 0) begin
         rec_t e, o;
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("FAIL t4_seq: got no seq_done, want cnt=%0d exp=%0d", e.cnt, e.expct);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("FAIL t4_seq: got cnt=%0d exp=%0d ok=%0b tot=%0d err=%0d at=%0d; want cnt=%0d exp=%0d ok=%0b tot=%0d err=%0d at=%0d",
                        o.cnt, o.expct, o.ok, o.total, o.errt, o.cyc, e.cnt, e.expct, e.ok, e.total, e.errt, e.cyc);
            end
         end
      end
      compared++;
      if (obs_q.size() != 0 || len_q.size() != 0) begin
         mismatched++;
         $display("FAIL t4_extra: got extra closes=%0d len_err=%0d, want 0 and 0", obs_q.size(), len_q.size());
      end
   endtask

   task automatic test_rise_at_gap_limit;
      do_reset(1'b0);
      drive(1'b0, 5);
      burst(2, -1, 0, GAP - 1);
      drive(1'b0, 20);
      while (exp_q.size() > 0) begin
         rec_t e, o;
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("FAIL t5_seq: got no seq_done, want cnt=%0d exp=%0d", e.cnt, e.expct);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("FAIL t5_seq: got cnt=%0d exp=%0d ok=%0b tot=%0d err=%0d at=%0d; want cnt=%0d exp=%0d ok=%0b tot=%0d err=%0d at=%0d",
                        o.cnt, o.expct, o.ok, o.total, o.errt, o.cyc, e.cnt, e.expct, e.ok, e.total, e.errt, e.cyc);
            end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++;
         $display("FAIL t5_extra: got extra closes=%0d, want 0", obs_q.size());
      end
   endtask

   task automatic test_reset_mid_burst;
      do_reset(1'b0);
      drive(1'b0, 5);
      burst(2, -1, 0, 6);
      drive(1'b0, 20);
      pulse(PL, 3, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      compared++;
      if ({bus.seq_done, bus.seq_ok, bus.len_err, bus.seq_pulse_cnt, bus.seq_expected,
           bus.seq_total, bus.err_total} !== 67'd0) begin
         mismatched++;
         $display("FAIL t6_rst_outputs: got done=%b ok=%b len=%b cnt=%0d exp=%0d tot=%0d err=%0d, want all 0",
                  bus.seq_done, bus.seq_ok, bus.len_err, bus.seq_pulse_cnt, bus.seq_expected,
                  bus.seq_total, bus.err_total);
      end
      clear_all();
      rst = 1'b0;
      drive(1'b0, 5);
      burst(2, -1, 0, 6);
      drive(1'b0, 20);
      while (exp_q.size() > 0) begin
         rec_t e, o;
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("FAIL t6_seq: got no seq_done, want cnt=%0d exp=%0d", e.cnt, e.expct);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("FAIL t6_seq: got cnt=%0d exp=%0d ok=%0b tot=%0d err=%0d at=%0d; want cnt=%0d exp=%0d ok=%0b tot=%0d err=%0d at=%0d",
                        o.cnt, o.expct, o.ok, o.total, o.errt, o.cyc, e.cnt, e.expct, e.ok, e.total, e.errt, e.cyc);
            end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++;
         $display("FAIL t6_extra: got extra closes=%0d, want 0", obs_q.size());
      end
   endtask

   initial begin
      bus.prime_seq = 1'b0;
      test_reset();
      test_prime_bursts();
      test_len_err();
      test_resync();
      test_armed_release();
      test_rise_at_gap_limit();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
